boot_rom_bridge: RTL and testbench

- Slave-side adapter between the core instruction/data memory port (req/gnt/rvalid protocol, with an added rready back-pressure) and the boot ROM macro's CSN/A/Q port.
- Decodes byte addresses to ROM word indices and rejects writes, misaligned and out-of-range accesses with an error response.
- Holds a response under back-pressure without re-reading the ROM.
- Sits directly upstream of the boot ROM. It is the only block that drives the ROM's CSN and A.

---
 rtl/boot_rom_bridge.sv | 127 ++++++++++++
 tb/tb_boot_rom_bridge.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/boot_rom_bridge.sv
// Bridge from the core req/gnt/rvalid memory port (with rready back-pressure) to the boot ROM CSN/A/Q port.
// Optional build macro BOOT_ROM_BRIDGE_STATS_EN adds saturating read/error grant counters.
module boot_rom_bridge #(
    parameter int unsigned DEPTH    = 548,
    parameter int unsigned ROM_AW   = 10,
    parameter logic [31:0] ERR_DATA = 32'hBADB007E
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    input  logic              rready_i,
    output logic              rom_csn_o,
    output logic [ROM_AW-1:0] rom_a_o,
    input  logic [31:0]       rom_q_i,
    output logic              busy_o
`ifdef BOOT_ROM_BRIDGE_STATS_EN
    ,
    output logic [15:0]       rd_cnt_o,
    output logic [15:0]       err_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [ROM_AW:0] DEPTH_L = DEPTH[ROM_AW:0];

    state_t              state_q, state_d;
    logic [ROM_AW-1:0]   a_q, a_d;
    logic [ROM_AW-1:0]   word_idx;
    logic                acc_err;
    logic                gnt;
    logic                rd_gnt;
    logic                err_gnt;
    logic                unused_addr_hi;

    // Only the offset within the ROM window is decoded; higher bits alias.
    assign word_idx       = addr_i[ROM_AW+1:2];
    assign unused_addr_hi = ^addr_i[31:ROM_AW+2];

    assign acc_err = we_i | (addr_i[1:0] != 2'b00) | ({1'b0, word_idx} >= DEPTH_L);
    assign gnt     = req_i & ((state_q == IDLE) | rready_i);
    assign rd_gnt  = gnt & ~acc_err;
    assign err_gnt = gnt & acc_err;

    // State register; a_q remembers the index last presented to the ROM.
    always_ff @(posedge CLK or negedge RSTN) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!RSTN) begin
            state_q <= IDLE;
            a_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_d = state_q;
        a_d     = a_q;
        if (gnt) begin
            state_d = acc_err ? ERR : RESP;
        end else if ((state_q != IDLE) && rready_i) begin
            state_d = IDLE;
        end
        if (rd_gnt) begin
            a_d = word_idx;
        end
    end

    always_comb begin
        gnt_o     = gnt;
        busy_o    = (state_q != IDLE);
        rom_csn_o = ~rd_gnt;
        rom_a_o   = rd_gnt ? word_idx : a_q;
        rvalid_o  = 1'b0;
        err_o     = 1'b0;
        rdata_o   = '0;
        unique case (state_q)
            RESP: begin
                rvalid_o = 1'b1;
                rdata_o  = rom_q_i;
            end
            ERR: begin
                rvalid_o = 1'b1;
                err_o    = 1'b1;
                rdata_o  = ERR_DATA;
            end
            default: ;
        endcase
    end

`ifdef BOOT_ROM_BRIDGE_STATS_EN
    logic [15:0] rd_cnt_q, err_cnt_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            if (rd_gnt && (rd_cnt_q != 16'hFFFF)) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            if (err_gnt && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign rd_cnt_o  = rd_cnt_q;
    assign err_cnt_o = err_cnt_q;
`else
    logic unused_err_gnt;
    assign unused_err_gnt = err_gnt;
`endif

endmodule

// File: tb/tb_boot_rom_bridge.sv
// Self-checking bench for boot_rom_bridge: per-cycle vector table plus reset and counter sequences.
// A behavioural registered-address ROM model sits on the ROM port.
module tb_boot_rom_bridge;

    localparam int unsigned ROM_AW = 10;

    logic              CLK;
    logic              RSTN;
    logic              req_i;
    logic              we_i;
    logic [31:0]       addr_i;
    logic              gnt_o;
    logic              rvalid_o;
    logic [31:0]       rdata_o;
    logic              err_o;
    logic              rready_i;
    logic              rom_csn_o;
    logic [ROM_AW-1:0] rom_a_o;
    logic [31:0]       rom_q_i;
    logic              busy_o;
`ifdef BOOT_ROM_BRIDGE_STATS_EN
    logic [15:0]       rd_cnt_o;
    logic [15:0]       err_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    boot_rom_bridge dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .gnt_o     (gnt_o),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .err_o     (err_o),
        .rready_i  (rready_i),
        .rom_csn_o (rom_csn_o),
        .rom_a_o   (rom_a_o),
        .rom_q_i   (rom_q_i),
        .busy_o    (busy_o)
`ifdef BOOT_ROM_BRIDGE_STATS_EN
        ,
        .rd_cnt_o  (rd_cnt_o),
        .err_cnt_o (err_cnt_o)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] rom_word(input logic [ROM_AW-1:0] idx);
        case (idx)
            10'd0:         rom_word = 32'h0000_0013;
            10'd31, 10'd32: rom_word = 32'h0100_006F;
            10'd53:        rom_word = 32'h0000_0D17;
            default:       rom_word = {6'h2A, idx, 16'h5A5A};
        endcase
    endfunction

    // ROM captures A on the CSN-low edge; Q holds otherwise.
    initial rom_q_i = 32'h0;
    always @(posedge CLK) begin
        if (!rom_csn_o) rom_q_i <= rom_word(rom_a_o);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic        rready;
        logic        gnt;
        logic        csn;
        logic [9:0]  a;
        logic        rvalid;
        logic        err;
        logic        busy;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic req, input logic we, input logic [31:0] addr,
                                input logic rready, input logic gnt, input logic csn,
                                input logic [9:0] a, input logic rvalid, input logic err,
                                input logic [31:0] rdata);
        vec_t v;
        v.req = req; v.we = we; v.addr = addr; v.rready = rready;
        v.gnt = gnt; v.csn = csn; v.a = a; v.rvalid = rvalid; v.err = err;
        v.busy = rvalid; v.rdata = rdata;
        return v;
    endfunction

    task automatic drive(input logic req, input logic we, input logic [31:0] addr, input logic rready);
        req_i = req; we_i = we; addr_i = addr; rready_i = rready;
    endtask

    initial begin
        // One row per cycle: inputs for the cycle, outputs expected in that cycle.
        vecs[0]  = mk(1, 0, 32'h000, 1, 1, 0, 10'd0,   0, 0, 32'h0);
        vecs[1]  = mk(1, 0, 32'h07C, 1, 1, 0, 10'd31,  1, 0, 32'h0000_0013);
        vecs[2]  = mk(1, 0, 32'h080, 1, 1, 0, 10'd32,  1, 0, 32'h0100_006F);
        vecs[3]  = mk(0, 0, 32'h000, 1, 0, 1, 10'd32,  1, 0, 32'h0100_006F);
        vecs[4]  = mk(1, 0, 32'h0D4, 1, 1, 0, 10'd53,  0, 0, 32'h0);
        for (int i = 5; i < 10; i++)
            vecs[i] = mk(1, 0, 32'h000, 0, 0, 1, 10'd53, 1, 0, 32'h0000_0D17);
        vecs[10] = mk(1, 0, 32'h000, 1, 1, 0, 10'd0,   1, 0, 32'h0000_0D17);
        vecs[11] = mk(0, 0, 32'h000, 1, 0, 1, 10'd0,   1, 0, 32'h0000_0013);
        vecs[12] = mk(1, 1, 32'h000, 1, 1, 1, 10'd0,   0, 0, 32'h0);
        vecs[13] = mk(1, 0, 32'h890, 1, 1, 1, 10'd0,   1, 1, 32'hBADB_007E);
        vecs[14] = mk(1, 0, 32'h002, 1, 1, 1, 10'd0,   1, 1, 32'hBADB_007E);
        vecs[15] = mk(0, 0, 32'h000, 0, 0, 1, 10'd0,   1, 1, 32'hBADB_007E);
        vecs[16] = mk(0, 0, 32'h000, 1, 0, 1, 10'd0,   1, 1, 32'hBADB_007E);
        vecs[17] = mk(0, 0, 32'h000, 1, 0, 1, 10'd0,   0, 0, 32'h0);
        vecs[18] = mk(1, 0, 32'h88C, 1, 1, 0, 10'd547, 0, 0, 32'h0);
        vecs[19] = mk(0, 0, 32'h000, 1, 0, 1, 10'd547, 1, 0, rom_word(10'd547));

        RSTN = 1'b0;
        drive(0, 0, 32'h0, 0);
        #12;
        check("reset.rvalid", {31'b0, rvalid_o}, 32'd0);
        check("reset.err",    {31'b0, err_o},    32'd0);
        check("reset.busy",   {31'b0, busy_o},   32'd0);
        check("reset.gnt",    {31'b0, gnt_o},    32'd0);
        check("reset.csn",    {31'b0, rom_csn_o}, 32'd1);
        check("reset.a",      {22'b0, rom_a_o},  32'd0);
        RSTN = 1'b1;
        @(posedge CLK); #1;

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].rready);
            @(negedge CLK);
            check($sformatf("v%0d.gnt", i),    {31'b0, gnt_o},     {31'b0, vecs[i].gnt});
            check($sformatf("v%0d.csn", i),    {31'b0, rom_csn_o}, {31'b0, vecs[i].csn});
            check($sformatf("v%0d.rvalid", i), {31'b0, rvalid_o},  {31'b0, vecs[i].rvalid});
            check($sformatf("v%0d.busy", i),   {31'b0, busy_o},    {31'b0, vecs[i].busy});
            if (!vecs[i].csn)
                check($sformatf("v%0d.a", i), {22'b0, rom_a_o}, {22'b0, vecs[i].a});
            if (vecs[i].rvalid) begin
                check($sformatf("v%0d.err", i),   {31'b0, err_o}, {31'b0, vecs[i].err});
                check($sformatf("v%0d.rdata", i), rdata_o,        vecs[i].rdata);
            end
            @(posedge CLK); #1;
        end

        // Reset in the middle of an outstanding response drops it immediately.
        drive(1, 0, 32'h004, 0);
        @(posedge CLK); #1;
        drive(0, 0, 32'h0, 0);
        @(negedge CLK);
        check("rst_mid.rvalid_before", {31'b0, rvalid_o}, 32'd1);
        RSTN = 1'b0;
        #1;
        check("rst_mid.rvalid_async", {31'b0, rvalid_o}, 32'd0);
        check("rst_mid.busy_async",   {31'b0, busy_o},   32'd0);
        @(posedge CLK); #3;
        RSTN = 1'b1;
        drive(0, 0, 32'h0, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check($sformatf("rst_after%0d.rvalid", c), {31'b0, rvalid_o}, 32'd0);
            check($sformatf("rst_after%0d.csn", c),    {31'b0, rom_csn_o}, 32'd1);
        end

`ifdef BOOT_ROM_BRIDGE_STATS_EN
        @(posedge CLK); #1;
        check("stats.rd_reset",  {16'b0, rd_cnt_o},  32'd0);
        check("stats.err_reset", {16'b0, err_cnt_o}, 32'd0);
        drive(1, 0, 32'h000, 1); @(posedge CLK); #1;
        drive(1, 0, 32'h004, 1); @(posedge CLK); #1;
        drive(1, 0, 32'h008, 1); @(posedge CLK); #1;
        drive(1, 0, 32'h003, 1); @(posedge CLK); #1;
        drive(1, 1, 32'h000, 1); @(posedge CLK); #1;
        drive(0, 0, 32'h000, 1); @(posedge CLK); #1;
        check("stats.rd3",  {16'b0, rd_cnt_o},  32'd3);
        check("stats.err2", {16'b0, err_cnt_o}, 32'd2);
        drive(1, 0, 32'h000, 1);
        repeat (65537) @(posedge CLK);
        #1;
        drive(0, 0, 32'h000, 1);
        @(negedge CLK);
        check("stats.rd_sat",   {16'b0, rd_cnt_o},  32'h0000_FFFF);
        check("stats.err_hold", {16'b0, err_cnt_o}, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
